dnn_train_controller: RTL and testbench

- Banked-memory sequencer for a small DNN training datapath.
- A 32-bit `mode` word selects one of four operations: IDLE, LOAD (serially fill a bank from `in_data`), COMPUTE (element-wise multiply of two banks into a third, with a running accumulator) and READ (stream a bank out on `out_data`).
- Sits between the host-side stimulus/sequencer and the training datapath.
- Each operation's address sweep restarts whenever `mode` changes.

---
 rtl/dnn_train_controller.sv | 119 +++++++++++
 tb/tb_dnn_train_controller.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dnn_train_controller.sv
// dnn_train_controller: banked-memory sequencer for a small DNN training datapath.
// One 32-bit mode word picks IDLE / COMPUTE / LOAD / READ. The address sweep
// restarts at word 0 whenever the mode word changes.
module dnn_train_controller #(
  parameter int BANKS = 8,
  parameter int DEPTH = 256,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [31:0]   mode,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  localparam logic [3:0] OP_IDLE    = 4'd0;
  localparam logic [3:0] OP_COMPUTE = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_READ    = 4'd3;

  // Storage: BANKS x DEPTH words, never reset.
  logic [DW-1:0] mem_q [BANKS][DEPTH];

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] out_q, out_d;
  logic [31:0]   mode_q, mode_d;

  // Field decode; bank fields keep only their low bits (index modulo BANKS).
  logic [3:0]    op;
  logic [BW-1:0] bank_a, bank_b, bank_d;
  assign op     = mode[3:0];
  assign bank_a = mode[4  +: BW];
  assign bank_b = mode[8  +: BW];
  assign bank_d = mode[12 +: BW];

  logic          new_mode;
  logic [AW-1:0] addr_cur;
  logic [DW-1:0] rd_a, rd_b, prod, acc_sum;
  logic          mem_we;
  logic [BW-1:0] mem_wbank;
  logic [DW-1:0] mem_wdata;

  // Next-state: address sweep, accumulator, output register and bank write port.
  always_comb begin
    new_mode  = (mode != mode_q);
    addr_cur  = new_mode ? '0 : addr_q;
    // Reads happen before this edge's write, so D==A/B sees the old word.
    rd_a      = mem_q[bank_a][addr_cur];
    rd_b      = mem_q[bank_b][addr_cur];
    prod      = rd_a * rd_b;  // low DW bits are identical for signed and unsigned
    acc_sum   = (new_mode ? '0 : acc_q) + prod;

    addr_d    = addr_q;
    acc_d     = acc_q;
    out_d     = out_q;
    mode_d    = mode_q;
    mem_we    = 1'b0;
    mem_wbank = bank_a;
    mem_wdata = in_data;

    if (enable) begin
      mode_d = mode;
      addr_d = (addr_cur == ADDR_LAST) ? '0 : addr_cur + 1'b1;
      case (op)
        OP_LOAD: begin
          mem_we    = 1'b1;
          mem_wbank = bank_a;
          mem_wdata = in_data;
          out_d     = in_data;
        end
        OP_COMPUTE: begin
          mem_we    = 1'b1;
          mem_wbank = bank_d;
          mem_wdata = prod;
          acc_d     = acc_sum;
          out_d     = acc_sum;
        end
        OP_READ: begin
          out_d = rd_a;
        end
        default: begin  // OP_IDLE and unused opcodes
          out_d  = '0;
          acc_d  = '0;
          addr_d = '0;
        end
      endcase
    end
  end

  // Control registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      mode_q <= '0;
    end else begin
      addr_q <= addr_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      mode_q <= mode_d;
    end
  end

  // Bank write port; a reset edge performs no write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem_q[mem_wbank][addr_cur] <= mem_wdata;
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_dnn_train_controller.sv
// Directed bench for dnn_train_controller with hand-computed expectations.
module tb_dnn_train_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] mode;
  logic [31:0] in_data;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  dnn_train_controller #(.BANKS(8), .DEPTH(256), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .in_data  (in_data),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle before sampling.
  task automatic cyc(input logic rst, input logic en, input logic [31:0] m, input logic [31:0] d);
    reset   = rst;
    enable  = en;
    mode    = m;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = '0; in_data = '0;

    // reset, then enable low holds everything
    cyc(1, 0, 32'h0, 0);
    chk("rst_out", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0142, 5);
      chk("en_hold", out_data, 0);
    end
    cyc(0, 1, 32'h0142, 5);
    chk("first_load_echo", out_data, 5);
    cyc(0, 1, 32'h0043, 0);
    chk("bank4_0", out_data, 5);
    cyc(0, 1, 32'h0, 0);
    chk("idle_out", out_data, 0);

    // LOAD/READ round trip
    for (int i = 0; i < 256; i++) begin
      cyc(0, 1, 32'h0142, i % 2);
      chk("load_echo", out_data, i % 2);
    end
    for (int i = 0; i < 256; i++) begin
      cyc(0, 1, 32'h0043, 0);
      chk("rd_bank4", out_data, i % 2);
    end

    // COMPUTE: bank1 = bank0 * bank4, running sum k(k+1)
    cyc(0, 1, 32'h0, 0);
    for (int i = 0; i < 96; i++) cyc(0, 1, 32'h0102, i + 1);
    for (int i = 0; i < 96; i++) cyc(0, 1, 32'h0142, 2);
    for (int i = 0; i < 96; i++) begin
      cyc(0, 1, 32'h1401, 0);
      chk("comp_acc", out_data, (i + 1) * (i + 2));
    end
    chk("comp_final", out_data, 9312);
    for (int i = 0; i < 96; i++) begin
      cyc(0, 1, 32'h0013, 0);
      chk("rd_bank1", out_data, 2 * (i + 1));
    end

    // chained layer: bank2 = bank1 * bank4
    cyc(0, 1, 32'h0, 0);
    chk("chain_idle", out_data, 0);
    for (int i = 0; i < 96; i++) begin
      cyc(0, 1, 32'h2411, 0);
      chk("chain_acc", out_data, 2 * (i + 1) * (i + 2));
    end
    chk("chain_final", out_data, 18624);
    for (int i = 0; i < 96; i++) begin
      cyc(0, 1, 32'h0023, 0);
      chk("rd_bank2", out_data, 4 * (i + 1));
    end

    // enable low holds a nonzero output; unused opcode acts as IDLE
    cyc(0, 0, 32'h0043, 0);
    chk("hold_nz", out_data, 384);
    cyc(0, 0, 32'h0043, 0);
    chk("hold_nz2", out_data, 384);
    cyc(0, 1, 32'h0007, 0);
    chk("op7_idle", out_data, 0);

    // wrap: 258 writes into bank0, words 0/1 overwritten by 256/257
    for (int i = 0; i < 258; i++) cyc(0, 1, 32'h0102, i);
    cyc(0, 1, 32'h0003, 0);
    chk("wrap_w0", out_data, 256);
    cyc(0, 1, 32'h0003, 0);
    chk("wrap_w1", out_data, 257);
    cyc(0, 1, 32'h0003, 0);
    chk("wrap_w2", out_data, 2);

    // mid-stream switch lands on word 0 of the new bank
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h0102, 9);
    cyc(0, 1, 32'h0112, 77);
    cyc(0, 1, 32'h0013, 0);
    chk("switch_b1w0", out_data, 77);

    // reset mid-COMPUTE
    cyc(0, 1, 32'h0, 0);
    for (int i = 0; i < 96; i++) cyc(0, 1, 32'h0102, i + 1);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 32'h1401, 0);
      chk("pre_rst_acc", out_data, (i + 1) * (i + 2));
    end
    cyc(1, 1, 32'h1401, 0);
    chk("mid_rst_out", out_data, 0);
    cyc(0, 1, 32'h1401, 0);
    chk("restart_e0", out_data, 2);
    cyc(0, 1, 32'h1401, 0);
    chk("restart_e1", out_data, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
